// File: rtl/pipe_stage_regs.sv
// rtl/pipe_stage_regs.sv - Y86 PIPE F/D/E/M/W pipeline registers with stall/bubble control
// Also holds the sticky halted/control-error flags and the cycle/retire counters.
module pipe_stage_regs #(
    parameter int             W        = 64,
    parameter int             CNT_W    = 32,
    parameter logic [W-1:0]   RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 F_stall,
    input  logic                 D_stall,
    input  logic                 D_bubble,
    input  logic                 E_bubble,
    input  logic                 M_bubble,
    input  logic                 W_stall,
    input  logic [W-1:0]         f_predPC,
    input  logic [20+2*W-1:0]    d_next,
    input  logic [28+3*W-1:0]    e_next,
    input  logic [17+2*W-1:0]    m_next,
    input  logic [16+2*W-1:0]    w_next,
    output logic [W-1:0]         F_predPC,
    output logic [20+2*W-1:0]    D_q,
    output logic [28+3*W-1:0]    E_q,
    output logic [17+2*W-1:0]    M_q,
    output logic [16+2*W-1:0]    W_q,
    output logic                 halted,
    output logic                 ctl_err,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     retired_cnt
);

    localparam int DW = 20 + 2*W;
    localparam int EW = 28 + 3*W;
    localparam int MW = 17 + 2*W;
    localparam int WW = 16 + 2*W;

    localparam logic [3:0] AOK   = 4'h8;
    localparam logic [3:0] NOP   = 4'h1;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // Nop images: stat AOK, icode NOP, register IDs RNONE, everything else zero.
    localparam logic [DW-1:0] D_BUBBLE = {AOK, NOP, 4'h0, RNONE, RNONE, {(2*W){1'b0}}};
    localparam logic [EW-1:0] E_BUBBLE = {AOK, NOP, 4'h0, {(3*W){1'b0}},
                                          RNONE, RNONE, RNONE, RNONE};
    localparam logic [MW-1:0] M_BUBBLE = {AOK, NOP, 1'b0, {(2*W){1'b0}}, RNONE, RNONE};
    localparam logic [WW-1:0] W_BUBBLE = {AOK, NOP, {(2*W){1'b0}}, RNONE, RNONE};

    logic [W-1:0]      f_pc_q,    f_pc_d;
    logic [DW-1:0]     d_reg_q,   d_reg_d;
    logic [EW-1:0]     e_reg_q,   e_reg_d;
    logic [MW-1:0]     m_reg_q,   m_reg_d;
    logic [WW-1:0]     w_reg_q,   w_reg_d;
    logic              halted_q,  halted_d;
    logic              ctl_err_q, ctl_err_d;
    logic [CNT_W-1:0]  cycle_q,   cycle_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic [3:0]        w_stat;
    logic [3:0]        w_icode;
    logic              w_retire;

    assign w_stat  = w_reg_q[WW-1 -: 4];
    assign w_icode = w_reg_q[WW-5 -: 4];

    // Bubbles never count as retired; a halted core retires nothing further.
    assign w_retire = !W_stall && !halted_q && (w_stat == AOK) && (w_icode != NOP);

    always_comb begin
        f_pc_d    = F_stall ? f_pc_q : f_predPC;
        d_reg_d   = D_stall ? d_reg_q : (D_bubble ? D_BUBBLE : d_next);
        e_reg_d   = E_bubble ? E_BUBBLE : e_next;
        m_reg_d   = M_bubble ? M_BUBBLE : m_next;
        w_reg_d   = W_stall ? w_reg_q : w_next;
        halted_d  = halted_q | (w_stat != AOK);
        ctl_err_d = ctl_err_q | (D_stall & D_bubble);
        cycle_d   = halted_q ? cycle_q : cycle_q + CNT_ONE;
        retired_d = w_retire ? retired_q + CNT_ONE : retired_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc_q    <= RESET_PC;
            d_reg_q   <= D_BUBBLE;
            e_reg_q   <= E_BUBBLE;
            m_reg_q   <= M_BUBBLE;
            w_reg_q   <= W_BUBBLE;
            halted_q  <= 1'b0;
            ctl_err_q <= 1'b0;
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            f_pc_q    <= f_pc_d;
            d_reg_q   <= d_reg_d;
            e_reg_q   <= e_reg_d;
            m_reg_q   <= m_reg_d;
            w_reg_q   <= w_reg_d;
            halted_q  <= halted_d;
            ctl_err_q <= ctl_err_d;
            cycle_q   <= cycle_d;
            retired_q <= retired_d;
        end
    end

    assign F_predPC    = f_pc_q;
    assign D_q         = d_reg_q;
    assign E_q         = e_reg_q;
    assign M_q         = m_reg_q;
    assign W_q         = w_reg_q;
    assign halted      = halted_q;
    assign ctl_err     = ctl_err_q;
    assign cycle_cnt   = cycle_q;
    assign retired_cnt = retired_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// tb/tb_pipe_stage_regs.sv - directed and randomized checks of pipe_stage_regs against a field-level model
module tb_pipe_stage_regs;

    localparam int W  = 64;
    localparam int DW = 20 + 2*W;
    localparam int EW = 28 + 3*W;
    localparam int MW = 17 + 2*W;
    localparam int WW = 16 + 2*W;

    localparam logic [3:0] AOK   = 4'h8;
    localparam logic [3:0] NOP   = 4'h1;
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [W-1:0] Z = '0;

    logic clk = 1'b0;
    logic reset, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic [W-1:0]  f_predPC;
    logic [DW-1:0] d_next;
    logic [EW-1:0] e_next;
    logic [MW-1:0] m_next;
    logic [WW-1:0] w_next;

    logic [W-1:0]  F_predPC;
    logic [DW-1:0] D_q;
    logic [EW-1:0] E_q;
    logic [MW-1:0] M_q;
    logic [WW-1:0] W_q;
    logic          halted, ctl_err;
    logic [31:0]   cycle_cnt, retired_cnt;

    logic [W-1:0]  F4;
    logic [DW-1:0] D4;
    logic [EW-1:0] E4;
    logic [MW-1:0] M4;
    logic [WW-1:0] W4;
    logic          halted4, ctl_err4;
    logic [3:0]    cycle4, retired4;

    pipe_stage_regs dut (
        .clk(clk), .reset(reset), .F_stall(F_stall), .D_stall(D_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .f_predPC(f_predPC), .d_next(d_next), .e_next(e_next), .m_next(m_next), .w_next(w_next),
        .F_predPC(F_predPC), .D_q(D_q), .E_q(E_q), .M_q(M_q), .W_q(W_q),
        .halted(halted), .ctl_err(ctl_err), .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
    );

    pipe_stage_regs #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .F_stall(F_stall), .D_stall(D_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .f_predPC(f_predPC), .d_next(d_next), .e_next(e_next), .m_next(m_next), .w_next(w_next),
        .F_predPC(F4), .D_q(D4), .E_q(E4), .M_q(M4), .W_q(W4),
        .halted(halted4), .ctl_err(ctl_err4), .cycle_cnt(cycle4), .retired_cnt(retired4)
    );

    initial forever #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model state, kept as whole-stage images assembled from named fields.
    logic [W-1:0]  x_f;
    logic [DW-1:0] x_d;
    logic [EW-1:0] x_e;
    logic [MW-1:0] x_m;
    logic [WW-1:0] x_w;
    bit            x_halt, x_err;
    int unsigned   x_cyc, x_ret;

    function automatic logic [DW-1:0] d_pack(logic [3:0] st, logic [3:0] ic, logic [3:0] fn,
                                             logic [3:0] ra, logic [3:0] rb,
                                             logic [W-1:0] valc, logic [W-1:0] valp);
        return {st, ic, fn, ra, rb, valc, valp};
    endfunction

    function automatic logic [MW-1:0] m_pack(logic [3:0] st, logic [3:0] ic, logic cnd,
                                             logic [W-1:0] vale, logic [W-1:0] vala,
                                             logic [3:0] de, logic [3:0] dm);
        return {st, ic, cnd, vale, vala, de, dm};
    endfunction

    function automatic logic [WW-1:0] w_pack(logic [3:0] st, logic [3:0] ic,
                                             logic [W-1:0] vale, logic [W-1:0] valm,
                                             logic [3:0] de, logic [3:0] dm);
        return {st, ic, vale, valm, de, dm};
    endfunction

    logic [DW-1:0] D_BUB;
    logic [EW-1:0] E_BUB;
    logic [MW-1:0] M_BUB;
    logic [WW-1:0] W_BUB;

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic randomize_data(input bit aok_only);
        logic [255:0] r;
        r = rnd256(); f_predPC = r[W-1:0];
        r = rnd256(); d_next   = r[DW-1:0];
        r = rnd256(); e_next   = r[EW-1:0];
        r = rnd256(); m_next   = r[MW-1:0];
        r = rnd256(); w_next   = r[WW-1:0];
        if (aok_only || $urandom_range(0, 24) != 0) w_next[WW-1 -: 4] = AOK;
        else w_next[WW-1 -: 4] = 4'h4;
    endtask

    task automatic idle_ctl();
        reset = 0; F_stall = 0; D_stall = 0; D_bubble = 0;
        E_bubble = 0; M_bubble = 0; W_stall = 0;
    endtask

    task automatic model_edge();
        if (reset) begin
            x_f = Z; x_d = D_BUB; x_e = E_BUB; x_m = M_BUB; x_w = W_BUB;
            x_halt = 0; x_err = 0; x_cyc = 0; x_ret = 0;
        end else begin
            if (!x_halt) x_cyc++;
            if (!W_stall && !x_halt && x_w[WW-1 -: 4] == AOK && x_w[WW-5 -: 4] != NOP) x_ret++;
            if (x_w[WW-1 -: 4] != AOK) x_halt = 1;
            if (D_stall && D_bubble) x_err = 1;
            if (!F_stall) x_f = f_predPC;
            if (!D_stall) x_d = D_bubble ? D_BUB : d_next;
            x_e = E_bubble ? E_BUB : e_next;
            x_m = M_bubble ? M_BUB : m_next;
            if (!W_stall) x_w = w_next;
        end
    endtask

    task automatic check_all();
        chk("F_predPC", 256'(F_predPC), 256'(x_f));
        chk("D_q", 256'(D_q), 256'(x_d));
        chk("E_q", 256'(E_q), 256'(x_e));
        chk("M_q", 256'(M_q), 256'(x_m));
        chk("W_q", 256'(W_q), 256'(x_w));
        chk("halted", 256'(halted), 256'(x_halt));
        chk("ctl_err", 256'(ctl_err), 256'(x_err));
        chk("cycle_cnt", 256'(cycle_cnt), 256'(x_cyc));
        chk("retired_cnt", 256'(retired_cnt), 256'(x_ret));
        chk("cycle_cnt4", 256'(cycle4), 256'(x_cyc % 16));
        chk("retired_cnt4", 256'(retired4), 256'(x_ret % 16));
        chk("halted4", 256'(halted4), 256'(x_halt));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    int unsigned saved_cyc, saved_ret;

    initial begin
        D_BUB = d_pack(AOK, NOP, 4'h0, RNONE, RNONE, Z, Z);
        E_BUB = {AOK, NOP, 4'h0, Z, Z, Z, RNONE, RNONE, RNONE, RNONE};
        M_BUB = m_pack(AOK, NOP, 1'b0, Z, Z, RNONE, RNONE);
        W_BUB = w_pack(AOK, NOP, Z, Z, RNONE, RNONE);

        // 1) reset held two cycles
        idle_ctl(); randomize_data(1);
        reset = 1; F_stall = 1; D_stall = 1; D_bubble = 1; W_stall = 1;
        step(); step();
        chk("rst_pc", 256'(F_predPC), 256'(0));
        chk("rst_D_icode", 256'(D_q[DW-5 -: 4]), 256'(4'h1));
        chk("rst_W_stat", 256'(W_q[WW-1 -: 4]), 256'(4'h8));
        chk("rst_M_dstE", 256'(M_q[7:4]), 256'(4'hF));
        chk("rst_cnt", 256'({cycle_cnt, retired_cnt, halted, ctl_err}), 256'(0));

        // 2) D stall holds icode 5 while E bubbles, then icode 6 loads
        idle_ctl(); randomize_data(1);
        d_next = d_pack(AOK, 4'h5, 4'h0, 4'h1, 4'h2, 64'h55, 64'h66);
        step();
        D_stall = 1; E_bubble = 1;
        d_next = d_pack(AOK, 4'h6, 4'h0, 4'h3, 4'h4, 64'h77, 64'h88);
        step();
        chk("t2_D_hold", 256'(D_q[DW-5 -: 4]), 256'(4'h5));
        chk("t2_E_bub", 256'(E_q), 256'(E_BUB));
        D_stall = 0; E_bubble = 0;
        step();
        chk("t2_D_load", 256'(D_q[DW-5 -: 4]), 256'(4'h6));

        // 3) stall and bubble together: hold plus sticky error
        d_next = d_pack(AOK, 4'h7, 4'h0, 4'h0, 4'h0, 64'h1, 64'h2);
        D_stall = 1; D_bubble = 1;
        step();
        chk("t3_D_hold", 256'(D_q[DW-5 -: 4]), 256'(4'h6));
        chk("t3_err", 256'(ctl_err), 256'(1));
        D_stall = 0; D_bubble = 0;
        step(); step();
        chk("t3_err_sticky", 256'(ctl_err), 256'(1));

        // 4) M bubble discards icode 3 / valE 0x10
        m_next = m_pack(AOK, 4'h3, 1'b1, 64'h10, 64'h20, 4'h2, 4'h3);
        M_bubble = 1;
        step();
        chk("t4_M_icode", 256'(M_q[MW-5 -: 4]), 256'(4'h1));
        chk("t4_M_valE", 256'(M_q[8+2*W-1 -: W]), 256'(0));
        chk("t4_M_stat", 256'(M_q[MW-1 -: 4]), 256'(4'h8));
        M_bubble = 0;

        // 5) non-AOK status reaches W, W stalled, halt freezes counters
        w_next = w_pack(4'h4, 4'h2, 64'h1, 64'h2, 4'h0, 4'h1);
        step();
        chk("t5_not_yet", 256'(halted), 256'(0));
        W_stall = 1; randomize_data(1);
        step();
        chk("t5_halted", 256'(halted), 256'(1));
        chk("t5_W_hold", 256'(W_q[WW-1 -: 4]), 256'(4'h4));
        saved_cyc = x_cyc; saved_ret = x_ret;
        for (int i = 0; i < 3; i++) begin
            randomize_data(1);
            step();
        end
        chk("t5_cyc_frozen", 256'(cycle_cnt), 256'(saved_cyc));
        chk("t5_ret_frozen", 256'(retired_cnt), 256'(saved_ret));
        chk("t5_err_kept", 256'(ctl_err), 256'(1));

        // 6) 17 retiring instructions wrap the 4-bit counters
        idle_ctl(); reset = 1;
        step();
        reset = 0;
        for (int i = 0; i < 18; i++) begin
            randomize_data(1);
            w_next = w_pack(AOK, 4'h2, 64'(i), 64'(i + 100), 4'h3, 4'hF);
            step();
            if (i == 15) chk("t6_ret4_at15", 256'(retired4), 256'(15));
            if (i == 16) chk("t6_ret4_wrap", 256'(retired4), 256'(0));
        end
        chk("t6_ret4", 256'(retired4), 256'(1));
        chk("t6_cyc4", 256'(cycle4), 256'(2));
        chk("t6_ret32", 256'(retired_cnt), 256'(17));

        // Random traffic with occasional resets and halts
        for (int i = 0; i < 400; i++) begin
            randomize_data(0);
            reset    = ($urandom_range(0, 29) == 0);
            F_stall  = ($urandom_range(0, 3) == 0);
            D_stall  = ($urandom_range(0, 3) == 0);
            D_bubble = ($urandom_range(0, 3) == 0);
            E_bubble = ($urandom_range(0, 3) == 0);
            M_bubble = ($urandom_range(0, 3) == 0);
            W_stall  = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
